// File: rtl/rom_bus_responder_pkg.sv
// Shared definitions for the 4001-style ROM bus responder: slot phases,
// opcode constants and the slot sequencing helper.
package rom_bus_responder_pkg;

  localparam int CHIP_ID_W = 4;

  localparam logic [3:0] OPR_SRC   = 4'h2;
  localparam logic [7:0] INSTR_WRR = 8'hE2;
  localparam logic [7:0] INSTR_RDR = 8'hEA;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_e;

  // The slot that follows p when sync stays low; IDLE absorbs everything after X3.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_A1:   next_phase = PH_A2;
      PH_A2:   next_phase = PH_A3;
      PH_A3:   next_phase = PH_M1;
      PH_M1:   next_phase = PH_M2;
      PH_M2:   next_phase = PH_X1;
      PH_X1:   next_phase = PH_X2;
      PH_X2:   next_phase = PH_X3;
      default: next_phase = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rom_bus_responder_rom_array.sv
// 256x8 program store with a synchronous load port and a registered read
// that returns the pre-write contents when both hit the same address.
module rom_array (
  input  logic       clk,
  input  logic       rstN,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [256];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  // Hold the last read unless a new one is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Image contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rom_bus_responder.sv
// 4001-style ROM bus responder: tracks the 8-slot instruction cycle, returns
// the addressed byte in M1/M2 and services SRC/WRR/RDR on its I/O port.
module rom_bus_responder
  import rom_bus_responder_pkg::*;
#(
  parameter logic [CHIP_ID_W-1:0] CHIP_ID = 4'h0
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       sync,
  input  logic       cmRomN,
  input  logic [3:0] busIn,
  output logic [3:0] busOut,
  output logic       busOe,
  input  logic       progWe,
  input  logic [7:0] progAddr,
  input  logic [7:0] progData,
  input  logic [3:0] ioIn,
  output logic [3:0] ioOut
);

  phase_e     phase_q, phase_d, slot_s;
  logic [3:0] addr_low_q, addr_low_d;
  logic [3:0] addr_mid_q, addr_mid_d;
  logic       selected_q, selected_d;
  logic [7:0] instr_q, instr_d;
  logic       io_sel_q, io_sel_d;
  logic [3:0] io_out_q, io_out_d;
  logic       rd_en_s;
  logic [7:0] data_s;
  logic       bus_oe_s;
  logic [3:0] bus_out_s;
  logic       is_src_s;

  rom_array u_rom (
    .clk     (clk),
    .rstN    (rstN),
    .wr_en   (progWe),
    .wr_addr (progAddr),
    .wr_data (progData),
    .rd_en   (rd_en_s),
    .rd_addr ({addr_mid_q, addr_low_q}),
    .rd_data (data_s)
  );

  // sync overrides whatever slot was expected, which aborts a partial cycle.
  always_comb begin
    slot_s     = sync ? PH_A1 : phase_q;
    phase_d    = next_phase(slot_s);
    addr_low_d = addr_low_q;
    addr_mid_d = addr_mid_q;
    selected_d = selected_q;
    instr_d    = instr_q;
    io_sel_d   = io_sel_q;
    io_out_d   = io_out_q;
    rd_en_s    = 1'b0;
    bus_oe_s   = 1'b0;
    bus_out_s  = 4'h0;
    is_src_s   = (instr_q[7:4] == OPR_SRC) && instr_q[0];
    case (slot_s)
      PH_A1: addr_low_d = busIn;
      PH_A2: addr_mid_d = busIn;
      PH_A3: begin
        selected_d = (busIn == CHIP_ID) && !cmRomN;
        rd_en_s    = 1'b1;
      end
      PH_M1: begin
        instr_d[7:4] = busIn;
        bus_oe_s     = selected_q;
        bus_out_s    = selected_q ? data_s[7:4] : 4'h0;
      end
      PH_M2: begin
        instr_d[3:0] = busIn;
        bus_oe_s     = selected_q;
        bus_out_s    = selected_q ? data_s[3:0] : 4'h0;
      end
      PH_X2: begin
        if (is_src_s && !cmRomN) begin
          io_sel_d = (busIn == CHIP_ID);
        end else if (io_sel_q && (instr_q == INSTR_WRR)) begin
          io_out_d = busIn;
        end else if (io_sel_q && (instr_q == INSTR_RDR)) begin
          bus_oe_s  = 1'b1;
          bus_out_s = ioIn;
        end else begin
          io_sel_d = io_sel_q;
        end
      end
      default: begin
        bus_oe_s = 1'b0;
      end
    endcase
  end

  // Slot, address, decode and I/O state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      phase_q    <= PH_IDLE;
      addr_low_q <= 4'h0;
      addr_mid_q <= 4'h0;
      selected_q <= 1'b0;
      instr_q    <= 8'h00;
      io_sel_q   <= 1'b0;
      io_out_q   <= 4'h0;
    end else begin
      phase_q    <= phase_d;
      addr_low_q <= addr_low_d;
      addr_mid_q <= addr_mid_d;
      selected_q <= selected_d;
      instr_q    <= instr_d;
      io_sel_q   <= io_sel_d;
      io_out_q   <= io_out_d;
    end
  end

  assign busOe  = bus_oe_s;
  assign busOut = bus_out_s;
  assign ioOut  = io_out_q;

endmodule
